// File: rtl/fila_pedidos.sv
// -----------------------------------------------------------------------------
// fila_pedidos -- elevator stop queue.
//
// Each accepted request (origem -> destino) becomes two stops in a circular
// buffer: the pickup stop {origem, 1} followed by the drop-off stop
// {destino, 0}. A small write FSM captures the request and writes the stops.
// The movement controller pops the head stop with `shift` and flushes the
// queue with `clear`.
//
// Optional feature (macro FILA_MERGE_ORIGEM_EN):
//   When defined, a request whose pickup floor equals the floor of the newest
//   queued stop reuses that stop. Only the drop-off stop is written, and only
//   one free entry is needed. When undefined, every accepted request writes
//   two entries.
//
// Parameters:
//   FLOOR_W  bit width of a floor number
//   DEPTH    number of queue entries (power of two, >= 4)
//
// Ports:
//   clock          sole clock, rising edge
//   reset          asynchronous, active-low reset
//   clear          synchronous flush of queue and write FSM
//   novo_pedido    one-cycle request strobe, samples origem/destino
//   origem         pickup floor of the new request
//   destino        drop-off floor of the new request
//   shift          pop the head stop (ignored when empty)
//   andar_atual    current floor of the car
//   andar_alvo     floor of the head stop (0 when empty)
//   eh_origem      head stop is a pickup stop
//   temDestino     queue non-empty
//   sobe           head floor above the current floor
//   chegouDestino  queue non-empty and head floor equals the current floor
//   cheia          fewer than two free entries
//   vazia          queue empty
//   erro_pedido    one-cycle pulse when a request is rejected
//   db_estado      current write-FSM state (debug)
// -----------------------------------------------------------------------------
module fila_pedidos #(
  parameter int FLOOR_W = 2,
  parameter int DEPTH   = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic               novo_pedido,
  input  logic [FLOOR_W-1:0] origem,
  input  logic [FLOOR_W-1:0] destino,
  input  logic               shift,
  input  logic [FLOOR_W-1:0] andar_atual,
  output logic [FLOOR_W-1:0] andar_alvo,
  output logic               eh_origem,
  output logic               temDestino,
  output logic               sobe,
  output logic               chegouDestino,
  output logic               cheia,
  output logic               vazia,
  output logic               erro_pedido,
  output logic [1:0]         db_estado
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO   = CNT_W'(2);
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    OCIOSO        = 2'd0,
    GRAVA_ORIGEM  = 2'd1,
    GRAVA_DESTINO = 2'd2,
    REJEITA       = 2'd3
  } estado_t;

  estado_t            state_r;
  estado_t            stateNext_s;
  logic [FLOOR_W-1:0] origemLatch_r;
  logic [FLOOR_W-1:0] destinoLatch_r;
  logic [FLOOR_W-1:0] memFloor_r [DEPTH];
  logic               memOrig_r  [DEPTH];
  logic [PTR_W-1:0]   rdPtr_r;
  logic [PTR_W-1:0]   wrPtr_r;
  logic [CNT_W-1:0]   count_r;

  logic [CNT_W-1:0]   freeSlots_s;
  logic               empty_s;
  logic               wrEn_s;
  logic               rdEn_s;
  logic               fullOk_s;
  logic               mergeOk_s;
  logic [FLOOR_W-1:0] wrFloor_s;
  logic               wrOrig_s;
  logic [FLOOR_W-1:0] headFloor_s;
  logic               headOrig_s;

  assign empty_s     = (count_r == {CNT_W{1'b0}});
  assign freeSlots_s = CNT_DEPTH - count_r;
  assign fullOk_s    = (origem != destino) && (freeSlots_s >= CNT_TWO);

`ifdef FILA_MERGE_ORIGEM_EN
  // The newest queued stop sits just behind the write pointer.
  logic [FLOOR_W-1:0] tailFloor_s;
  assign tailFloor_s = memFloor_r[wrPtr_r - PTR_ONE];
  assign mergeOk_s   = (origem != destino) && !empty_s &&
                       (origem == tailFloor_s) && (freeSlots_s >= CNT_ONE);
`else
  assign mergeOk_s   = 1'b0;
`endif

  // Both write states store one entry; the state selects which stop.
  assign wrEn_s    = (state_r == GRAVA_ORIGEM) || (state_r == GRAVA_DESTINO);
  assign wrOrig_s  = (state_r == GRAVA_ORIGEM);
  assign wrFloor_s = wrOrig_s ? origemLatch_r : destinoLatch_r;
  assign rdEn_s    = shift && !empty_s;

  // Write FSM next-state decision.
  always_comb begin
    stateNext_s = state_r;
    case (state_r)
      OCIOSO: begin
        if (novo_pedido) begin
          if (mergeOk_s) begin
            stateNext_s = GRAVA_DESTINO;
          end else if (fullOk_s) begin
            stateNext_s = GRAVA_ORIGEM;
          end else begin
            stateNext_s = REJEITA;
          end
        end else begin
          stateNext_s = OCIOSO;
        end
      end
      GRAVA_ORIGEM:  stateNext_s = GRAVA_DESTINO;
      GRAVA_DESTINO: stateNext_s = OCIOSO;
      REJEITA:       stateNext_s = OCIOSO;
      default:       stateNext_s = OCIOSO;
    endcase
  end

  // Write FSM state register; clear aborts any request in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= OCIOSO;
    end else if (clear) begin
      state_r <= OCIOSO;
    end else begin
      state_r <= stateNext_s;
    end
  end

  // Request capture; only sampled while idle so later strobes are ignored.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      origemLatch_r  <= {FLOOR_W{1'b0}};
      destinoLatch_r <= {FLOOR_W{1'b0}};
    end else if ((state_r == OCIOSO) && novo_pedido && !clear) begin
      origemLatch_r  <= origem;
      destinoLatch_r <= destino;
    end else begin
      origemLatch_r  <= origemLatch_r;
      destinoLatch_r <= destinoLatch_r;
    end
  end

  // Pointers and occupancy; a write and a pop in the same cycle cancel out.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdPtr_r <= {PTR_W{1'b0}};
      wrPtr_r <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else if (clear) begin
      rdPtr_r <= {PTR_W{1'b0}};
      wrPtr_r <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else begin
      rdPtr_r <= rdEn_s ? (rdPtr_r + PTR_ONE) : rdPtr_r;
      wrPtr_r <= wrEn_s ? (wrPtr_r + PTR_ONE) : wrPtr_r;
      case ({wrEn_s, rdEn_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage. It needs no reset because every output is masked while
  // the queue is empty.
  always_ff @(posedge clock) begin
    if (wrEn_s && !clear) begin
      memFloor_r[wrPtr_r] <= wrFloor_s;
      memOrig_r[wrPtr_r]  <= wrOrig_s;
    end
  end

  assign headFloor_s = memFloor_r[rdPtr_r];
  assign headOrig_s  = memOrig_r[rdPtr_r];

  assign andar_alvo    = empty_s ? {FLOOR_W{1'b0}} : headFloor_s;
  assign eh_origem     = !empty_s && headOrig_s;
  assign temDestino    = !empty_s;
  assign sobe          = !empty_s && (headFloor_s > andar_atual);
  assign chegouDestino = !empty_s && (headFloor_s == andar_atual);
  assign cheia         = (freeSlots_s < CNT_TWO);
  assign vazia         = empty_s;
  assign erro_pedido   = (state_r == REJEITA);
  assign db_estado     = state_r;

endmodule

// File: tb/tb_fila_pedidos.sv
// -----------------------------------------------------------------------------
// tb_fila_pedidos -- self-checking bench for fila_pedidos (default parameters).
// The reference model is a queue of stops plus a list of stops still waiting
// to be written. On every falling edge, the DUT outputs are compared with the
// values derived from that model. Directed scenarios also pin literal values.
// -----------------------------------------------------------------------------
module tb_fila_pedidos;

  logic       clock = 1'b0;
  logic       reset;
  logic       clear;
  logic       novo_pedido;
  logic [1:0] origem;
  logic [1:0] destino;
  logic       shift;
  logic [1:0] andar_atual;
  logic [1:0] andar_alvo;
  logic       eh_origem;
  logic       temDestino;
  logic       sobe;
  logic       chegouDestino;
  logic       cheia;
  logic       vazia;
  logic       erro_pedido;
  logic [1:0] db_estado;

  int checks = 0;
  int errors = 0;

  // Model: each stop is {floor, pickup flag}.
  logic [2:0] mq[$];
  logic [2:0] pend[$];
  bit         rej = 1'b0;
  bit         cmpEn = 1'b0;

  fila_pedidos dut (
    .clock        (clock),
    .reset        (reset),
    .clear        (clear),
    .novo_pedido  (novo_pedido),
    .origem       (origem),
    .destino      (destino),
    .shift        (shift),
    .andar_atual  (andar_atual),
    .andar_alvo   (andar_alvo),
    .eh_origem    (eh_origem),
    .temDestino   (temDestino),
    .sobe         (sobe),
    .chegouDestino(chegouDestino),
    .cheia        (cheia),
    .vazia        (vazia),
    .erro_pedido  (erro_pedido),
    .db_estado    (db_estado)
  );

  always #5 clock = ~clock;

  task automatic modelStep();
    int         occ;
    bit         idle;
    bit         hasW;
    bit         merge;
    logic [2:0] w;
    logic [2:0] tail;
    if (!reset || clear) begin
      mq.delete();
      pend.delete();
      rej = 1'b0;
    end else begin
      occ  = mq.size();
      idle = (pend.size() == 0) && !rej;
      hasW = (pend.size() > 0);
      w    = 3'b000;
      if (hasW) w = pend.pop_front();
      if (rej) begin
        rej = 1'b0;
      end else if (idle && novo_pedido) begin
        merge = 1'b0;
`ifdef FILA_MERGE_ORIGEM_EN
        if (occ > 0) begin
          tail  = mq[occ-1];
          merge = (origem != destino) && (tail[2:1] == origem) && (8 - occ >= 1);
        end
`endif
        if (merge) begin
          pend.push_back({destino, 1'b0});
        end else if ((origem != destino) && (8 - occ >= 2)) begin
          pend.push_back({origem, 1'b1});
          pend.push_back({destino, 1'b0});
        end else begin
          rej = 1'b1;
        end
      end
      if (shift && occ > 0) void'(mq.pop_front());
      if (hasW) mq.push_back(w);
    end
  endtask

  task automatic compareNow();
    logic [2:0]  h;
    bit          e;
    logic [1:0]  db;
    logic [10:0] expV;
    logic [10:0] gotV;
    e = (mq.size() == 0);
    h = 3'b000;
    if (!e) h = mq[0];
    if (rej)                    db = 2'd3;
    else if (pend.size() == 2)  db = 2'd1;
    else if (pend.size() == 1)  db = 2'd2;
    else                        db = 2'd0;
    expV = {h[2:1], h[0], !e, (!e && (h[2:1] > andar_atual)),
            (!e && (h[2:1] == andar_atual)), ((8 - mq.size()) < 2), e, rej, db};
    gotV = {andar_alvo, eh_origem, temDestino, sobe, chegouDestino,
            cheia, vazia, erro_pedido, db_estado};
    checks++;
    if (gotV !== expV) begin
      errors++;
      $display("FAIL outputs t=%0t got %b required %b (alvo,eh,tem,sobe,cheg,cheia,vazia,erro,db)",
               $time, gotV, expV);
    end
  endtask

  // Model update on every active edge and on reset assertion.
  initial begin
    forever begin
      @(posedge clock or negedge reset);
      modelStep();
    end
  end

  // Per-cycle comparison, away from the rising edge.
  initial begin
    forever begin
      @(negedge clock);
      if (cmpEn) compareNow();
    end
  end

  task automatic chk(input string nm, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s got %0d required %0d", nm, got, req);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic req(input logic [1:0] o, input logic [1:0] d);
    origem = o;
    destino = d;
    novo_pedido = 1'b1;
    step();
    novo_pedido = 1'b0;
    step();
    step();
  endtask

  task automatic pop(input int n);
    shift = 1'b1;
    repeat (n) step();
    shift = 1'b0;
  endtask

  initial begin
    logic [1:0] o;
    logic [1:0] d;
    logic [1:0] prevD;
    reset = 1'b1; clear = 1'b0; novo_pedido = 1'b0; shift = 1'b0;
    origem = 2'd0; destino = 2'd0; andar_atual = 2'd0;
    #1 reset = 1'b0;
    #1;
    chk("reset_vazia", vazia, 1);
    chk("reset_tem", temDestino, 0);
    chk("reset_db", db_estado, 0);
    chk("reset_erro", erro_pedido, 0);
    cmpEn = 1'b1;
    repeat (2) step();
    reset = 1'b1;
    step();

    // Basic request 1->3 from floor 0.
    req(2'd1, 2'd3);
    chk("p13_alvo", andar_alvo, 1);
    chk("p13_eh", eh_origem, 1);
    chk("p13_sobe", sobe, 1);
    chk("p13_tem", temDestino, 1);
    chk("p13_occ", mq.size(), 2);

    // Arrive at pickup, pop, then arrive at drop-off.
    andar_atual = 2'd1; #1;
    chk("at1_cheg", chegouDestino, 1);
    pop(1);
    chk("pop1_alvo", andar_alvo, 3);
    chk("pop1_eh", eh_origem, 0);
    chk("pop1_cheg", chegouDestino, 0);
    andar_atual = 2'd3; #1;
    chk("at3_cheg", chegouDestino, 1);
    chk("at3_sobe", sobe, 0);
    pop(1);
    chk("pop2_vazia", vazia, 1);
    chk("pop2_alvo", andar_alvo, 0);

    // Same-floor request is rejected for one cycle.
    andar_atual = 2'd0;
    origem = 2'd2; destino = 2'd2; novo_pedido = 1'b1;
    step();
    novo_pedido = 1'b0;
    chk("rej_erro", erro_pedido, 1);
    chk("rej_db", db_estado, 3);
    step();
    chk("rej_erro_off", erro_pedido, 0);
    chk("rej_vazia", vazia, 1);

    // Fill to capacity and check the full-queue rejection.
    req(2'd1, 2'd2); req(2'd2, 2'd3); req(2'd3, 2'd0);
    chk("six_cheia", cheia, 0);
    req(2'd2, 2'd0);
    chk("eight_cheia", cheia, 1);
    pop(1);
    chk("seven_cheia", cheia, 1);
    chk("seven_occ", mq.size(), 7);
    chk("seven_alvo", andar_alvo, 2);
    origem = 2'd0; destino = 2'd1; novo_pedido = 1'b1;
    step();
    novo_pedido = 1'b0;
`ifdef FILA_MERGE_ORIGEM_EN
    chk("merge_db", db_estado, 2);
    step(); step();
    chk("merge_occ", mq.size(), 8);
`else
    chk("full_erro", erro_pedido, 1);
    step(); step();
    chk("full_occ", mq.size(), 7);
`endif
    pop(9);
    chk("drain_vazia", vazia, 1);

    // Pop during GRAVA_DESTINO keeps occupancy.
    req(2'd1, 2'd2);
    origem = 2'd3; destino = 2'd0; novo_pedido = 1'b1;
    step();
    novo_pedido = 1'b0;
    step();
    shift = 1'b1;
    step();
    shift = 1'b0;
    chk("wrsh_occ", mq.size(), 3);
    chk("wrsh_alvo", andar_alvo, 2);
    chk("wrsh_eh", eh_origem, 0);
    pop(3);

    // 20 requests with one stop always left over, wrapping the pointers.
    req(2'd3, 2'd1);
    pop(1);
    prevD = 2'd1;
    for (int i = 0; i < 20; i++) begin
      o = 2'(i % 4);
      d = 2'((i % 4 + 1 + i % 3) % 4);
      req(o, d);
      chk("wrap_head", andar_alvo, prevD);
      pop(1);
      chk("wrap_orig", andar_alvo, o);
      pop(1);
      chk("wrap_dest", andar_alvo, d);
      prevD = d;
    end
    pop(1);

    // Clear during GRAVA_ORIGEM.
    req(2'd1, 2'd3);
    origem = 2'd0; destino = 2'd2; novo_pedido = 1'b1;
    step();
    novo_pedido = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_vazia", vazia, 1);
    chk("clr_db", db_estado, 0);
    step();

    // Reset in the middle of a request.
    origem = 2'd1; destino = 2'd2; novo_pedido = 1'b1;
    step();
    novo_pedido = 1'b0;
    step();
    reset = 1'b0;
    #1;
    chk("rst_vazia", vazia, 1);
    chk("rst_db", db_estado, 0);
    chk("rst_erro", erro_pedido, 0);
    step();
    reset = 1'b1;
    step(); step();
    chk("rst_discard", vazia, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
